// File: rtl/cos_job_dispatcher_pkg.sv
// Shared definitions for the cos(x) job dispatcher: FSM encoding and datapath widths.
package cos_job_dispatcher_pkg;

    localparam int unsigned X_W   = 16;  // angle operand width
    localparam int unsigned Y_W   = 8;   // precision operand width
    localparam int unsigned R_W   = 16;  // engine result width
    localparam int unsigned CNT_W = 8;   // timeout counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

endpackage

// File: rtl/cos_job_fifo.sv
// Synchronous job FIFO; pointers carry one extra wrap bit so full and empty
// are told apart without a separate occupancy counter.
module cos_job_fifo
    import cos_job_dispatcher_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 28
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer advance for accepted pushes and pops.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/cos_job_dispatcher.sv
// Job dispatcher in front of the cos(x) engine: buffers tagged jobs, issues
// them one at a time with stable operands, bounds each run with a timeout,
// and presents the result with its tag on a valid/ready port.
module cos_job_dispatcher
    import cos_job_dispatcher_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [X_W-1:0]   in_x,
    input  logic [Y_W-1:0]   in_y,
    output logic             eng_start,
    output logic [X_W-1:0]   eng_x,
    output logic [Y_W-1:0]   eng_y,
    input  logic             eng_done,
    input  logic [R_W-1:0]   eng_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [R_W-1:0]   out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int unsigned FW = TAG_W + X_W + Y_W;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W-1:0]   cur_tag_q, cur_tag_d;
    logic [X_W-1:0]     eng_x_q, eng_x_d;
    logic [Y_W-1:0]     eng_y_q, eng_y_d;
    logic               eng_start_q, eng_start_d;
    logic               out_valid_q, out_valid_d;
    logic [R_W-1:0]     out_data_q, out_data_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               out_err_q, out_err_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FW-1:0]      fifo_rdata;
    logic [TAG_W-1:0]   head_tag;
    logic [X_W-1:0]     head_x;
    logic [Y_W-1:0]     head_y;

    // Gated by rst so the port reads 0 while reset is held.
    assign in_ready  = rst && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign {head_tag, head_x, head_y} = fifo_rdata;

    cos_job_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i ({tag_q, in_x, in_y}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Tag counter advances once per accepted job, wrapping modulo 2^TAG_W.
    always_comb begin
        tag_d = tag_q;
        if (fifo_push) begin
            tag_d = tag_q + TAG_W'(1);
        end
    end

    // Next-state and output-register logic for the dispatch FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_tag_d   = cur_tag_q;
        eng_x_d     = eng_x_q;
        eng_y_d     = eng_y_q;
        eng_start_d = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_err_d   = out_err_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    cur_tag_d   = head_tag;
                    eng_x_d     = head_x;
                    eng_y_d     = head_y;
                    eng_start_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_LOAD;
                end
            end
            // Counter is zeroed on entry to LOAD and counts through LOAD and RUN,
            // so it equals cycles since eng_start; the abort lands TIMEOUT+1 after it.
            ST_LOAD: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (eng_done) begin
                    out_data_d  = eng_out;
                    out_err_d   = 1'b0;
                    out_tag_d   = cur_tag_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    out_data_d  = '0;
                    out_err_d   = 1'b1;
                    out_tag_d   = cur_tag_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tag_q       <= '0;
            cur_tag_q   <= '0;
            eng_x_q     <= '0;
            eng_y_q     <= '0;
            eng_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            cur_tag_q   <= cur_tag_d;
            eng_x_q     <= eng_x_d;
            eng_y_q     <= eng_y_d;
            eng_start_q <= eng_start_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_err_q   <= out_err_d;
        end
    end

    assign eng_start = eng_start_q;
    assign eng_x     = eng_x_q;
    assign eng_y     = eng_y_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_cos_job_dispatcher.sv
// Scoreboard bench for cos_job_dispatcher with a behavioural engine model.
`timescale 1ns/1ps
module tb_cos_job_dispatcher;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TIMEOUT = 255;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_x;
    logic [7:0]       in_y;
    logic             eng_start;
    logic [15:0]      eng_x;
    logic [7:0]       eng_y;
    logic             eng_done;
    logic [15:0]      eng_out;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    typedef struct {
        logic [15:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               lat;
        logic [15:0]      x;
        logic [7:0]       y;
    } exp_t;

    typedef struct {
        logic [15:0] x;
        logic [7:0]  y;
        logic [15:0] res;
        int          lat;
    } job_t;

    exp_t sb[$];
    job_t eng_q[$];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int n_starts  = 0;
    int start_cyc = 0;
    int n_outs    = 0;
    int acc_cyc   = 0;
    int spur_req  = 0;
    logic [TAG_W-1:0] exp_tag = '0;

    cos_job_dispatcher #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .eng_start (eng_start),
        .eng_x     (eng_x),
        .eng_y     (eng_y),
        .eng_done  (eng_done),
        .eng_out   (eng_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Offer one job and hold it until accepted; leaves in_valid high so jobs
    // can be issued back to back. Entered and left at posedge+#1.
    task automatic push_job(input logic [15:0] x, input logic [7:0] y,
                            input logic [15:0] res, input int lat, output int pc);
        exp_t e;
        job_t j;
        int   n;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        pc = cyc;
        if (!in_ready) begin
            fail_now("push_timeout");
        end else begin
            if (lat == 0 || lat > int'(TIMEOUT)) begin
                e.data = 16'h0000; e.err = 1'b1; e.lat = int'(TIMEOUT) + 1;
            end else begin
                e.data = res;      e.err = 1'b0; e.lat = lat + 1;
            end
            e.tag = exp_tag;
            e.x   = x;
            e.y   = y;
            sb.push_back(e);
            j.x = x; j.y = y; j.res = res; j.lat = lat;
            eng_q.push_back(j);
            exp_tag = exp_tag + 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_start(input int base, output int sc);
        int n;
        n = 0;
        while (n_starts == base && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n_starts == base) fail_now("start_timeout");
        sc = start_cyc;
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) fail_now("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Engine model: checks operands at each launch, answers after the job's latency
    // (0 = never), and emits stray done pulses on request while idle.
    initial begin : engine
        logic        busy;
        int          left;
        int          spur_done;
        logic [15:0] res;
        job_t        j;
        busy = 1'b0; left = 0; spur_done = 0; res = '0;
        eng_done = 1'b0; eng_out = '0;
        forever begin
            @(posedge clk); #1;
            eng_done = 1'b0;
            eng_out  = '0;
            if (!rst) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    if (left == 1) begin
                        eng_done = 1'b1; eng_out = res; busy = 1'b0;
                    end else if (left > 1) begin
                        left--;
                    end
                end else if (spur_done < spur_req) begin
                    eng_done = 1'b1; eng_out = 16'hDEAD; spur_done++;
                end
                if (eng_start) begin
                    n_starts++;
                    start_cyc = cyc;
                    if (eng_q.size() == 0) begin
                        fail_now("unexpected_eng_start");
                    end else begin
                        j = eng_q.pop_front();
                        chk("eng_x_at_start", eng_x, j.x);
                        chk("eng_y_at_start", eng_y, j.y);
                        busy = 1'b1; left = j.lat; res = j.res;
                    end
                end
            end
        end
    end

    // Monitor: compares each presented result with the scoreboard head and
    // checks the output stays frozen while stalled.
    initial begin : monitor
        logic             seen;
        logic [15:0]      d0;
        logic [TAG_W-1:0] t0;
        logic             e0;
        exp_t             e;
        seen = 1'b0; d0 = '0; t0 = '0; e0 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1; d0 = out_data; t0 = out_tag; e0 = out_err;
                    if (sb.size() == 0) fail_now("unexpected_out_valid");
                    else chk("latency_start_to_valid", cyc - start_cyc, sb[0].lat);
                end else begin
                    chk("held_output", {out_data, out_tag, out_err}, {d0, t0, e0});
                end
                if (out_ready) begin
                    seen    = 1'b0;
                    acc_cyc = cyc;
                    n_outs++;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_tag", out_tag, e.tag);
                        chk("out_err", out_err, e.err);
                        chk("eng_x_stable", eng_x, e.x);
                        chk("eng_y_stable", eng_y, e.y);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int pc, pc1, sc, base, ns, no, n;
        rst = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {in_ready, eng_start, eng_x, eng_y, out_valid, out_data, out_tag, out_err}, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", in_ready, 1'b1);
        @(posedge clk); #1;

        // 1: single job, launch two cycles after push
        base = n_starts;
        push_job(16'h1000, 8'h10, 16'h7A00, 10, pc);
        in_valid = 1'b0;
        wait_start(base, sc);
        chk("push_to_start_gap", sc - pc, 2);
        drain(200);

        // 2: back-to-back pushes fill the FIFO; a sixth waits for space
        push_job(16'h0100, 8'h01, 16'h2001, 3, pc1);
        push_job(16'h0200, 8'h02, 16'h2002, 3, pc);
        push_job(16'h0300, 8'h03, 16'h2003, 3, pc);
        push_job(16'h0400, 8'h04, 16'h2004, 3, pc);
        push_job(16'h0500, 8'h05, 16'h2005, 3, pc);
        chk("b2b_accept_span", pc - pc1, 4);
        @(negedge clk);
        chk("in_ready_when_full", in_ready, 1'b0);
        @(posedge clk); #1;
        push_job(16'h0600, 8'h06, 16'h2006, 3, pc);
        in_valid = 1'b0;
        drain(300);

        // 3: timeout, done on the last allowed cycle, late done, then a normal job
        push_job(16'h3333, 8'h33, 16'hBEEF, 0, pc);
        push_job(16'h4444, 8'h44, 16'h5555, 255, pc);
        push_job(16'h6666, 8'h66, 16'h7777, 256, pc);
        push_job(16'h8888, 8'h88, 16'h1234, 4, pc);
        in_valid = 1'b0;
        drain(1500);

        // 4: consumer stalls in EMIT; no launch until release
        out_ready = 1'b0;
        push_job(16'h9001, 8'h91, 16'hA001, 5, pc);
        push_job(16'h9002, 8'h92, 16'hA002, 5, pc);
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("stall_out_valid_timeout");
        ns = n_starts;
        repeat (20) @(negedge clk);
        chk("no_start_during_stall", n_starts, ns);
        chk("valid_held_during_stall", out_valid, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        base = n_starts;
        wait_start(base, sc);
        chk("release_to_start_gap", sc - acc_cyc, 2);
        drain(100);

        // 5: reset during RUN with two jobs queued
        base = n_starts;
        push_job(16'h5001, 8'h51, 16'hB001, 50, pc);
        push_job(16'h5002, 8'h52, 16'hB002, 50, pc);
        push_job(16'h5003, 8'h53, 16'hB003, 50, pc);
        in_valid = 1'b0;
        wait_start(base, sc);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("outputs_zero_in_reset",
            {in_ready, eng_start, eng_x, eng_y, out_valid, out_data, out_tag, out_err}, '0);
        sb.delete();
        eng_q.delete();
        exp_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        ns = n_starts;
        no = n_outs;
        repeat (40) @(negedge clk);
        chk("no_start_after_reset", n_starts, ns);
        chk("no_output_after_reset", n_outs, no);
        @(posedge clk); #1;

        // 6: stray done pulses while idle, then 20 jobs wrap the tag
        no = n_outs;
        spur_req = spur_req + 3;
        repeat (10) @(negedge clk);
        chk("stray_done_ignored", n_outs, no);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            push_job(16'(i * 16'h0111), 8'(8'hF0 - i), 16'(16'hC000 + i), 1 + (i % 3), pc);
        end
        in_valid = 1'b0;
        drain(600);
        chk("jobs_after_reset_total", n_outs - no, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
